// File: rtl/fp_add_issue.sv
// fp_add_issue: operand issue and result-return stage in front of float_point_add.
// Requests are queued in a DEPTH-entry FIFO and issued one at a time. Each result
// is returned over a valid/ready handshake. A watchdog converts a hung adder into
// a qNaN result.
// Optional feature macro: FP_ADD_ZERO_BYPASS_EN (answer +-0 operands without the adder).
module fp_add_issue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iReqValid,
  output logic        oReqReady,
  input  logic [31:0] iReqA,
  input  logic [31:0] iReqB,
  input  logic [1:0]  iReqOp,
  output logic [31:0] oA,
  output logic [31:0] oB,
  output logic [1:0]  oOp,
  input  logic [31:0] iF,
  input  logic        iDone,
  output logic        oRspValid,
  input  logic        iRspReady,
  output logic [31:0] oRspF,
  output logic        oRspTimeout,
  output logic        oBusy
);

  localparam int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [7:0]  WD_LAST    = 8'(TIMEOUT - 1);
  localparam logic [31:0] QNAN       = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP,
    S_COOL
  } state_t;

  state_t          state, state_next;
  logic [65:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            push, pop;
  logic [65:0]     head;
  logic [31:0]     head_a, head_b;
  logic [1:0]      head_op;
  logic            head_legal;
  logic [7:0]      wd_cnt;
  logic            cool_cnt;
  logic            wd_expired;

  assign oReqReady  = (count < FULL_COUNT);
  assign oBusy      = (state != S_IDLE) || (count != '0);
  assign push       = iReqValid && oReqReady;
  assign pop        = (state == S_IDLE) && (count != '0);
  assign head       = mem[rd_ptr];
  assign head_a     = head[65:34];
  assign head_b     = head[33:2];
  assign head_op    = head[1:0];
  assign head_legal = (head_op == 2'b01) || (head_op == 2'b10);
  assign wd_expired = (wd_cnt == WD_LAST);

`ifdef FP_ADD_ZERO_BYPASS_EN
  logic        a_zero, b_zero, head_bypass;
  logic [31:0] bypass_f;
  assign a_zero      = (head_a[30:0] == '0);
  assign b_zero      = (head_b[30:0] == '0);
  assign head_bypass = head_legal && (a_zero || b_zero);

  // Result of an add/sub where at least one operand is +-0.
  always_comb begin
    bypass_f = '0;
    if (a_zero && b_zero) bypass_f = '0;
    else if (b_zero)      bypass_f = head_a;
    else                  bypass_f = {head_b[31] ^ (head_op == 2'b10), head_b[30:0]};
  end
`endif

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {iReqA, iReqB, iReqOp};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  // FSM next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (pop) begin
          if (!head_legal) state_next = S_RESP;
`ifdef FP_ADD_ZERO_BYPASS_EN
          else if (head_bypass) state_next = S_RESP;
`endif
          else state_next = S_ISSUE;
        end
      end
      S_ISSUE: if (iDone || wd_expired) state_next = S_RESP;
      S_RESP:  if (iRspReady)           state_next = S_COOL;
      S_COOL:  if (cool_cnt)            state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Registered outputs, watchdog and cool-down counters; iDone wins over the timeout.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      oA          <= '0;
      oB          <= '0;
      oOp         <= '0;
      oRspValid   <= 1'b0;
      oRspF       <= '0;
      oRspTimeout <= 1'b0;
      wd_cnt      <= '0;
      cool_cnt    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            oA     <= head_a;
            oB     <= head_b;
            wd_cnt <= '0;
            if (!head_legal) begin
              oRspF       <= QNAN;
              oRspTimeout <= 1'b0;
              oRspValid   <= 1'b1;
            end
`ifdef FP_ADD_ZERO_BYPASS_EN
            else if (head_bypass) begin
              oRspF       <= bypass_f;
              oRspTimeout <= 1'b0;
              oRspValid   <= 1'b1;
            end
`endif
            else begin
              oOp <= head_op;
            end
          end
        end
        S_ISSUE: begin
          if (iDone) begin
            oRspF       <= iF;
            oRspTimeout <= 1'b0;
            oRspValid   <= 1'b1;
            oOp         <= '0;
          end else if (wd_expired) begin
            oRspF       <= QNAN;
            oRspTimeout <= 1'b1;
            oRspValid   <= 1'b1;
            oOp         <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (iRspReady) begin
            oRspValid <= 1'b0;
            cool_cnt  <= 1'b0;
          end
        end
        S_COOL: cool_cnt <= ~cool_cnt;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fp_add_issue.md
# fp_add_issue

Operand issue and result-return stage placed directly upstream of `float_point_add`. Accepts add/sub requests over a valid/ready handshake and buffers them in a small FIFO. Presents one request at a time to the adder, holding operands stable until the adder's done pulse, and returns each result over a valid/ready response handshake. A watchdog turns a hung adder into a qNaN result.

## Interface
- `DEPTH`, 4: request FIFO entries; power of two, at least 2.
- `TIMEOUT`, 63: maximum ISSUE cycles without `iDone` before abort; 1..255.

- `clk` in 1: clock; all logic on the rising edge.
- `resetn` in 1: asynchronous active-low reset.
- `iReqValid` in 1: request present.
- `oReqReady` out 1: FIFO can accept; equals `count < DEPTH`.
- `iReqA` in 32: operand A, IEEE-754 single.
- `iReqB` in 32: operand B, IEEE-754 single.
- `iReqOp` in 2: 01 add, 10 sub; 00/11 are illegal.
- `oA` out 32: to adder `iA`.
- `oB` out 32: to adder `iB`.
- `oOp` out 2: to adder `iOp`; 00 (nop) outside ISSUE.
- `iF` in 32: adder `oF`.
- `iDone` in 1: adder `oDone`.
- `oRspValid` out 1: response held.
- `iRspReady` in 1: consumer accepts the response.
- `oRspF` out 32: result.
- `oRspTimeout` out 1: result produced by watchdog abort.
- `oBusy` out 1: FSM not IDLE, or FIFO not empty.

## Operation
- **FIFO:** 66-bit entries {A, B, op}.
  - Write pointer, read pointer and count; pointers wrap modulo `DEPTH`.
  - Push when `iReqValid && oReqReady`. Pop only from IDLE.
  - Push and pop in the same cycle leave count unchanged.
  - There is no pass-through: a request reaches the FIFO before it can be issued.
- **FSM states:** IDLE, ISSUE, RESP, COOL.
- **IDLE**
  - If count > 0: pop the head into the `oA`/`oB` registers and the op register.
  - Legal op: go to ISSUE.
  - Illegal op: set `oRspF` = 32'h7FC00000 and `oRspTimeout` = 0, then go to RESP.
  - Count = 0: stay in IDLE.
- **ISSUE**
  - `oOp` = held op. The watchdog counter starts at 0 on entry and increments each cycle.
  - `iDone`=1: capture `iF` into `oRspF`, clear `oRspTimeout`, go to RESP.
  - Counter reaches `TIMEOUT` with `iDone`=0: set `oRspF` = 32'h7FC00000 and `oRspTimeout` = 1, go to RESP.
  - If `iDone` and the timeout occur in the same cycle, `iDone` wins.
- **RESP**
  - `oOp` = 00 and `oRspValid` = 1.
  - `oRspF` and `oRspTimeout` stay stable until `iRspReady`=1, then go to COOL.
- **COOL:** 2 cycles with `oOp` = 00, which lets the adder rounding FSM settle in idle. Then go to IDLE.
- `oA`/`oB` keep their last values outside ISSUE; only `oOp` signals activity.
- `iDone` is ignored outside ISSUE.

## Timing
- **Reset values:** `oReqReady`=1 (FIFO empty); `oA`=0, `oB`=0, `oOp`=00; `oRspValid`=0, `oRspF`=0, `oRspTimeout`=0, `oBusy`=0. FSM=IDLE, pointers and count 0.
- **Reset mid-operation:** queued requests and any pending response are discarded, and `oOp` returns to 00 immediately (asynchronous).
- **Latency, accept to ISSUE:**
  - Request accepted at edge t into an empty FIFO with FSM in IDLE.
  - Pop at t+1.
  - `oOp`/`oA`/`oB` valid from t+2.
- **Latency, done to response:** `iDone` sampled at edge d gives `oRspValid`=1 from d+1.
- **Minimum spacing:** 4 cycles from response acceptance to the next ISSUE (2 COOL cycles, 1 IDLE cycle, then ISSUE).
- **Full FIFO:** `oReqReady`=0. A request presented while full is not captured; the upstream must hold it.
- All outputs are registered except `oReqReady` and `oBusy`, which decode registered state.

## Configuration
- **`FP_ADD_ZERO_BYPASS_EN` defined:** in IDLE, a legal-op head with a ±0 operand (bits [30:0]==0) skips ISSUE and goes straight to RESP. The result is:
  - A zero, B nonzero: B, with the sign inverted for sub.
  - B zero: A.
  - Both zero: 32'h00000000.
  - `oRspTimeout` = 0 in all bypass cases.
  - `oOp` stays 00 throughout the bypass.
- **Undefined:** every legal op goes through ISSUE. The bypass logic is not compiled.

## Test plan
- **Single add:** bench adder model pulses `iDone` 5 cycles after `oOp`=01. Push 3F800000 + 40000000, op 01, model returns 40400000.
  - Required: `oOp`=01 at t+2, `oRspF`=40400000 one cycle after `iDone`, `oRspTimeout`=0, then 2 COOL cycles with `oOp`=00.
- **FIFO full/wrap:** hold `iRspReady`=0 and push 6 requests with DEPTH=4.
  - Required: `oReqReady` drops after the 5th accept (4 queued, 1 in flight).
  - Release `iRspReady`: all 5 responses come out in order, pointers wrap correctly.
- **Watchdog:** model never asserts `iDone`.
  - Required: after 63 ISSUE cycles, `oRspF`=7FC00000 with `oRspTimeout`=1. The next request is issued normally afterwards.
- **Back-pressure:** `iRspReady`=0 for 10 cycles after a response.
  - Required: `oRspF` is stable and `oOp`=00 throughout; no pop occurs.
- **Illegal op 11:** required response is 7FC00000 with `oRspTimeout`=0, and `oOp` never leaves 00.
- **Bypass and reset:**
  - With `FP_ADD_ZERO_BYPASS_EN`: 00000000 − 3F800000 gives BF800000 with no ISSUE.
  - Without the macro: the same request goes to the adder.
  - `resetn` low during ISSUE: all outputs go to reset values and the FIFO is empty.
